// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver: per-digit registers, scan
// prescaler with anti-ghosting guard, blink/blank, and pin polarity control.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned BLINK_FRAMES   = 128,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [5:0]            wr_data,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [5:0]            r_digit [NUM_DIGITS];
    logic [CW-1:0]         r_cnt;
    logic [AW-1:0]         r_ptr;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blink_phase;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_ptr_last;
    logic                  w_blink_last;
    logic                  w_guard_done;
    logic [5:0]            w_cur;
    logic                  w_dark;
    logic [6:0]            w_seg_ah;
    logic                  w_dp_ah;
    logic [NUM_DIGITS-1:0] w_an_ah;

    function automatic logic [6:0] f_decode(input logic [3:0] hex);
        case (hex)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    assign w_slot_end   = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_ptr_last   = (r_ptr == AW'(NUM_DIGITS - 1));
    assign w_blink_last = (r_blink_cnt == BW'(BLINK_FRAMES - 1));

    // A zero-length guard would make the compare constant, so it is elaborated away.
    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign w_guard_done = 1'b1;
        end else begin : g_guard
            assign w_guard_done = (r_cnt >= CW'(GUARD_CYCLES));
        end
    endgenerate

    // Digit registers; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '{default: 6'b100000};
        end else if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
            r_digit[wr_addr] <= wr_data;
        end
    end

    // Scan prescaler, digit pointer and blink timebase; all parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!enable) begin
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_ptr <= w_ptr_last ? '0 : r_ptr + AW'(1);
            if (w_ptr_last) begin
                if (w_blink_last) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Active-high view of the pins for the current slot.
    always_comb begin
        w_seg_ah = '0;
        w_dp_ah  = 1'b0;
        w_an_ah  = '0;
        w_cur    = r_digit[r_ptr];
        w_dark   = w_cur[5] | (blink_mask[r_ptr] & r_blink_phase);
        if (enable && w_guard_done) begin
            w_an_ah[r_ptr] = 1'b1;
            if (!w_dark) begin
                w_seg_ah = f_decode(w_cur[3:0]);
                w_dp_ah  = w_cur[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_INV;
            r_dp         <= SEG_ACTIVE_LOW;
            r_an         <= AN_INV;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_ah ^ SEG_INV;
            r_dp         <= w_dp_ah ^ SEG_ACTIVE_LOW;
            r_an         <= w_an_ah ^ AN_INV;
            r_frame_done <= enable & w_slot_end & w_ptr_last;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-low 4-digit, active-high 4-digit
// and active-low 3-digit instances share one stimulus stream.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned GC = 2;
    localparam int unsigned BF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] blink_mask;

    logic [6:0] seg_a, seg_h, seg_r;
    logic       dp_a, dp_h, dp_r;
    logic [3:0] an_a, an_h;
    logic [2:0] an_r;
    logic       fd_a, fd_h, fd_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [5:0] exp_dig [4];
    logic [3:0] bm_m;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blink_mask(blink_mask),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) u_dut_h (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blink_mask(blink_mask),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(3), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut_r (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blink_mask(blink_mask[2:0]),
        .seg(seg_r), .dp(dp_r), .an(an_r), .frame_done(fd_r)
    );

    function automatic logic [6:0] f_dec(input logic [3:0] h);
        case (h)
            4'h0: f_dec = 7'h3F;  4'h1: f_dec = 7'h06;  4'h2: f_dec = 7'h5B;  4'h3: f_dec = 7'h4F;
            4'h4: f_dec = 7'h66;  4'h5: f_dec = 7'h6D;  4'h6: f_dec = 7'h7D;  4'h7: f_dec = 7'h07;
            4'h8: f_dec = 7'h7F;  4'h9: f_dec = 7'h6F;  4'hA: f_dec = 7'h77;  4'hB: f_dec = 7'h7C;
            4'hC: f_dec = 7'h39;  4'hD: f_dec = 7'h5E;  4'hE: f_dec = 7'h79;  default: f_dec = 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t cyc=%0d got=%0h exp=%0h", tag, $time, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs after edge number cyc reflect the scan state at index cyc-1.
    task automatic check_scan(input bit chk_r);
        int         s;
        int         c;
        logic [1:0] slot;
        logic       phase;
        logic       dark;
        logic [5:0] d;
        logic [3:0] an_ah, an_al;
        logic [6:0] seg_ah, seg_al;
        logic       dp_ah, dp_al;
        logic       fd;
        s      = cyc - 1;
        slot   = 2'(s / 8);
        c      = s % 8;
        phase  = ((s / 64) % 2) == 1;
        d      = exp_dig[slot];
        dark   = d[5] | (bm_m[slot] & phase);
        an_ah  = '0;
        seg_ah = '0;
        dp_ah  = 1'b0;
        if (c >= 2) begin
            an_ah[slot] = 1'b1;
            if (!dark) begin
                seg_ah = f_dec(d[3:0]);
                dp_ah  = d[4];
            end
        end
        an_al  = ~an_ah;
        seg_al = ~seg_ah;
        dp_al  = ~dp_ah;
        fd     = (s % 32) == 31;
        check("an_a",  32'(an_a),  32'(an_al));
        check("seg_a", 32'(seg_a), 32'(seg_al));
        check("dp_a",  32'(dp_a),  32'(dp_al));
        check("fd_a",  32'(fd_a),  32'(fd));
        check("an_h",  32'(an_h),  32'(an_ah));
        check("seg_h", 32'(seg_h), 32'(seg_ah));
        check("dp_h",  32'(dp_h),  32'(dp_ah));
        check("fd_h",  32'(fd_h),  32'(fd));
        if (chk_r) begin
            if (cyc == 20) begin
                check("an_r_slot2",  32'(an_r),  32'h3);
                check("seg_r_slot2", 32'(seg_r), 32'h30);
            end
            if (cyc == 28) begin
                check("an_r_slot0",  32'(an_r),  32'h6);
                check("seg_r_slot0", 32'(seg_r), 32'h79);
            end
            if (cyc == 23) check("fd_r_pre",  32'(fd_r), 32'h0);
            if (cyc == 24) check("fd_r_wrap", 32'(fd_r), 32'h1);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_an_a"},  32'(an_a),  32'hF);
        check({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
        check({tag, "_dp_a"},  32'(dp_a),  32'h1);
        check({tag, "_fd_a"},  32'(fd_a),  32'h0);
        check({tag, "_an_h"},  32'(an_h),  32'h0);
        check({tag, "_seg_h"}, 32'(seg_h), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 6'd0;
        blink_mask = 4'b0000;
        bm_m       = 4'b0000;
        for (int i = 0; i < 4; i++) exp_dig[i] = 6'b100000;

        // Reset held with enable high and the clock running.
        repeat (5) begin
            step();
            check_idle("reset");
            check("reset_dp_h", 32'(dp_h), 32'h0);
        end

        // Load digits 0..3 = 1,2,3,4 while disabled; addr 3 is out of range for the 3-digit instance.
        rst_n  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en      = 1'b1;
            wr_addr    = 2'(i);
            wr_data    = {2'b00, 4'(i + 1)};
            exp_dig[i] = {2'b00, 4'(i + 1)};
            step();
            check_idle("wr_idle");
        end
        wr_en = 1'b0;

        // Scan five frames with digit 0 blinking: lit, lit, dark, dark, lit.
        blink_mask = 4'b0001;
        bm_m       = 4'b0001;
        enable     = 1'b1;
        cyc        = 0;
        repeat (160) begin
            step();
            cyc++;
            check_scan(1'b1);
        end

        // Disable, then blank digit 2 and show 8 with dp on digit 1.
        enable = 1'b0;
        step();
        check_idle("dis1");
        blink_mask = 4'b0000;
        bm_m       = 4'b0000;
        wr_en      = 1'b1;
        wr_addr    = 2'd2;
        wr_data    = 6'b100000;
        exp_dig[2] = 6'b100000;
        step();
        wr_addr    = 2'd1;
        wr_data    = 6'b011000;
        exp_dig[1] = 6'b011000;
        step();
        wr_en = 1'b0;
        check_idle("dis_wr");

        // Restart from slot 0 with a full guard; drop enable mid-slot 2 of frame 1.
        enable = 1'b1;
        cyc    = 0;
        repeat (52) begin
            step();
            cyc++;
            check_scan(1'b0);
        end
        enable = 1'b0;
        step();
        check_idle("drop");

        // Rewrite digit 0 while it is displayed: new pattern lands two edges after the strobe.
        enable = 1'b1;
        cyc    = 0;
        repeat (4) begin
            step();
            cyc++;
            check_scan(1'b0);
        end
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 6'h07;
        step();
        cyc++;
        wr_en = 1'b0;
        check_scan(1'b0);
        exp_dig[0] = 6'h07;
        repeat (5) begin
            step();
            cyc++;
            check_scan(1'b0);
        end
        check("midwr_seg_a", 32'(seg_a), 32'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
